// File: rtl/pinwheel_ram_arbiter.sv
// pinwheel_ram_arbiter: independent round-robin read and write arbiters in front of one dual-port RAM.
// Define PINWHEEL_ARB_BYPASS_EN to forward same-cycle same-address write data into the read response.
module pinwheel_ram_arbiter #(
   parameter int requesters = 4,
   parameter int addr_bits  = 10,
   parameter int word_bits  = 32
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [requesters-1:0]           req_valid,
   input  logic [requesters-1:0]           req_write,
   input  logic [requesters*addr_bits-1:0] req_addr,
   input  logic [requesters*word_bits-1:0] req_wdata,
   output logic [requesters-1:0]           req_ready,
   output logic [requesters-1:0]           resp_valid,
   output logic [word_bits-1:0]            resp_data,
   output logic [addr_bits-1:0]            raddr,
   input  logic [word_bits-1:0]            rdata,
   output logic [addr_bits-1:0]            waddr,
   output logic [word_bits-1:0]            wdata,
   output logic                            wren
);
   localparam int PW = requesters > 1 ? $clog2(requesters) : 1;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [requesters-1:0] rd_cand, wr_cand, rd_gnt, wr_gnt, resp_q, resp_d;
   logic rd_found, wr_found;
   always_comb begin
      rd_cand  = reset_n ? req_valid & ~req_write : '0;
      wr_cand  = reset_n ? req_valid & req_write : '0;
      rd_gnt   = '0;
      wr_gnt   = '0;
      rd_found = 1'b0;
      wr_found = 1'b0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      // offset k from the pointer lands on requester i; first hit wins
      for (int k = 0; k < requesters; k++) begin
         for (int i = 0; i < requesters; i++) begin
            if (!rd_found && rd_cand[i] && ((int'(rd_ptr_q) + k) % requesters) == i) begin
               rd_found = 1'b1;
               rd_gnt[i] = 1'b1;
               rd_ptr_d = PW'((i + 1) % requesters);
            end
            if (!wr_found && wr_cand[i] && ((int'(wr_ptr_q) + k) % requesters) == i) begin
               wr_found = 1'b1;
               wr_gnt[i] = 1'b1;
               wr_ptr_d = PW'((i + 1) % requesters);
            end
         end
      end
      raddr = '0;
      waddr = '0;
      wdata = '0;
      for (int i = 0; i < requesters; i++) begin
         if (rd_gnt[i]) raddr = req_addr[i*addr_bits +: addr_bits];
         if (wr_gnt[i]) begin
            waddr = req_addr[i*addr_bits +: addr_bits];
            wdata = req_wdata[i*word_bits +: word_bits];
         end
      end
      wren      = wr_found;
      req_ready = rd_gnt | wr_gnt;
      resp_d    = rd_gnt;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         resp_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         resp_q   <= resp_d;
      end
   end
   assign resp_valid = resp_q;
`ifdef PINWHEEL_ARB_BYPASS_EN
   logic byp_q, byp_d;
   logic [word_bits-1:0] byp_data_q, byp_data_d;
   always_comb begin
      byp_d      = rd_found && wr_found && raddr == waddr;
      byp_data_d = wdata;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byp_q      <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
      end
   end
   assign resp_data = |resp_q ? (byp_q ? byp_data_q : rdata) : '0;
`else
   assign resp_data = |resp_q ? rdata : '0;
`endif
endmodule

// File: tb/tb_pinwheel_ram_arbiter.sv
// tb_pinwheel_ram_arbiter: directed checks of the arbiter against a read-old synchronous RAM model.
module tb_pinwheel_ram_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;
   logic [3:0] req_valid, req_write, req_ready, resp_valid;
   logic [39:0] req_addr;
   logic [127:0] req_wdata;
   logic [31:0] resp_data, rdata, wdata;
   logic [9:0] raddr, waddr;
   logic wren;
   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:1023];

   pinwheel_ram_arbiter #(.requesters(4), .addr_bits(10), .word_bits(32)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .raddr(raddr), .rdata(rdata),
      .waddr(waddr), .wdata(wdata), .wren(wren)
   );

   always @(posedge clk) begin
      if (wren) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

   function automatic logic [31:0] init_val(input int a);
      return 32'h1000 + a;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      req_valid = 4'hF;
      req_write = 4'h0;
      req_addr = {10'd40, 10'd30, 10'd20, 10'd10};
      req_wdata = {4{32'h5555AAAA}};
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready got %b expected 0000", req_ready); end
      checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL rst_resp_valid got %b expected 0000", resp_valid); end
      checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data got %h expected 0", resp_data); end
      checks++; if (raddr !== 10'd0) begin errors++; $display("FAIL rst_raddr got %0d expected 0", raddr); end
      req_write = 4'hF;
      #1;
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b expected 0", wren); end
      checks++; if (waddr !== 10'd0 || wdata !== 32'h0) begin errors++; $display("FAIL rst_wbus got %0d/%h expected 0/0", waddr, wdata); end
   endtask

   task automatic test_round_robin();
      int exp_g [5] = '{0, 1, 2, 3, 0};
      int g;
      @(negedge clk);
      reset_n = 1'b1;
      req_valid = 4'hF;
      req_write = 4'h0;
      req_addr = {10'd40, 10'd30, 10'd20, 10'd10};
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         g = exp_g[c];
         checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_ready cycle %0d got %b expected %b", c, req_ready, 4'(1 << g)); end
         checks++; if (raddr !== 10'(10 * (g + 1))) begin errors++; $display("FAIL rr_raddr cycle %0d got %0d expected %0d", c, raddr, 10 * (g + 1)); end
         checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rr_wren cycle %0d got %b expected 0", c, wren); end
         if (c > 0) begin
            checks++; if (resp_valid !== 4'(1 << exp_g[c-1])) begin errors++; $display("FAIL rr_resp_valid cycle %0d got %b expected %b", c, resp_valid, 4'(1 << exp_g[c-1])); end
            checks++; if (resp_data !== init_val(10 * (exp_g[c-1] + 1))) begin errors++; $display("FAIL rr_resp_data cycle %0d got %h expected %h", c, resp_data, init_val(10 * (exp_g[c-1] + 1))); end
         end else begin
            checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL rr_resp_first got %b expected 0000", resp_valid); end
         end
      end
      @(negedge clk);
      req_valid = 4'h0;
      #1;
      checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL rr_last_valid got %b expected 0001", resp_valid); end
      checks++; if (resp_data !== init_val(10)) begin errors++; $display("FAIL rr_last_data got %h expected %h", resp_data, init_val(10)); end
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rr_idle_ready got %b expected 0000", req_ready); end
   endtask

   task automatic test_rw_same_addr();
      logic [31:0] exp_d;
`ifdef PINWHEEL_ARB_BYPASS_EN
      exp_d = 32'hDEADBEEF;
`else
      exp_d = init_val(5);
`endif
      @(negedge clk);
      req_valid = 4'b0011;
      req_write = 4'b0001;
      req_addr = {10'd0, 10'd0, 10'd5, 10'd5};
      req_wdata = {96'd0, 32'hDEADBEEF};
      #1;
      checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rw_ready got %b expected 0011", req_ready); end
      checks++; if (wren !== 1'b1 || waddr !== 10'd5 || wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_wbus got %b/%0d/%h expected 1/5/deadbeef", wren, waddr, wdata); end
      checks++; if (raddr !== 10'd5) begin errors++; $display("FAIL rw_raddr got %0d expected 5", raddr); end
      @(negedge clk);
      req_valid = 4'h0;
      #1;
      checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL rw_resp_valid got %b expected 0010", resp_valid); end
      checks++; if (resp_data !== exp_d) begin errors++; $display("FAIL rw_resp_data got %h expected %h", resp_data, exp_d); end
      checks++; if (wren !== 1'b0 || waddr !== 10'd0 || wdata !== 32'h0) begin errors++; $display("FAIL rw_idle_wbus got %b/%0d/%h expected 0/0/0", wren, waddr, wdata); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      req_write = 4'h0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c < 8) begin
            req_valid = 4'b0100;
            req_addr = {10'd0, 10'(c), 20'd0};
         end else req_valid = 4'h0;
         #1;
         if (c < 8) begin
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready cycle %0d got %b expected 0100", c, req_ready); end
            checks++; if (raddr !== 10'(c)) begin errors++; $display("FAIL b2b_raddr cycle %0d got %0d expected %0d", c, raddr, c); end
         end
         if (c > 0) begin
            exp_d = (c - 1 == 5) ? 32'hDEADBEEF : init_val(c - 1);
            checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL b2b_resp_valid cycle %0d got %b expected 0100", c, resp_valid); end
            checks++; if (resp_data !== exp_d) begin errors++; $display("FAIL b2b_resp_data cycle %0d got %h expected %h", c, resp_data, exp_d); end
         end
      end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 4'h0 || resp_data !== 32'h0) begin errors++; $display("FAIL b2b_idle got %b/%h expected 0000/0", resp_valid, resp_data); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      req_valid = 4'b1001;
      req_write = 4'h0;
      req_addr = {10'd60, 10'd0, 10'd0, 10'd50};
      #1;
      checks++; if (req_ready !== 4'b1000 || raddr !== 10'd60) begin errors++; $display("FAIL wrap_first got %b/%0d expected 1000/60", req_ready, raddr); end
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0001 || raddr !== 10'd50) begin errors++; $display("FAIL wrap_second got %b/%0d expected 0001/50", req_ready, raddr); end
      checks++; if (resp_valid !== 4'b1000 || resp_data !== init_val(60)) begin errors++; $display("FAIL wrap_resp3 got %b/%h expected 1000/%h", resp_valid, resp_data, init_val(60)); end
      @(negedge clk);
      req_valid = 4'b0011;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr got %b expected 0010", req_ready); end
      checks++; if (resp_valid !== 4'b0001 || resp_data !== init_val(50)) begin errors++; $display("FAIL wrap_resp0 got %b/%h expected 0001/%h", resp_valid, resp_data, init_val(50)); end
      @(negedge clk);
      req_valid = 4'h0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 4'b0001;
      req_write = 4'h0;
      req_addr = {30'd0, 10'd7};
      #1;
      checks++; if (req_ready !== 4'b0001 || raddr !== 10'd7) begin errors++; $display("FAIL rstm_grant got %b/%0d expected 0001/7", req_ready, raddr); end
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (req_ready !== 4'h0 || raddr !== 10'd0) begin errors++; $display("FAIL rstm_async got %b/%0d expected 0000/0", req_ready, raddr); end
      @(posedge clk);
      #1;
      checks++; if (resp_valid !== 4'h0 || resp_data !== 32'h0) begin errors++; $display("FAIL rstm_resp got %b/%h expected 0000/0", resp_valid, resp_data); end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL rstm_resp_hold got %b expected 0000", resp_valid); end
   endtask

   task automatic test_writes_only();
      int cnt [4] = '{0, 0, 0, 0};
      @(negedge clk);
      reset_n = 1'b1;
      req_valid = 4'hF;
      req_write = 4'hF;
      req_addr = {10'd203, 10'd202, 10'd201, 10'd200};
      req_wdata = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL wr_ready cycle %0d got %b expected %b", c, req_ready, 4'(1 << (c % 4))); end
         checks++; if (wren !== 1'b1 || waddr !== 10'(200 + c % 4) || wdata !== 32'(32'hC0 + c % 4)) begin errors++; $display("FAIL wr_bus cycle %0d got %b/%0d/%h", c, wren, waddr, wdata); end
         checks++; if (raddr !== 10'd0 || resp_valid !== 4'h0) begin errors++; $display("FAIL wr_no_read cycle %0d got %0d/%b expected 0/0000", c, raddr, resp_valid); end
         for (int i = 0; i < 4; i++) if (req_ready[i] && wren) cnt[i]++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (cnt[i] !== 4) begin errors++; $display("FAIL wr_count req %0d got %0d expected 4", i, cnt[i]); end
      end
      @(negedge clk);
      req_write = 4'h0;
      #1;
      checks++; if (req_ready !== 4'b0001 || wren !== 1'b0) begin errors++; $display("FAIL rd_ptr_after_reset got %b/%b expected 0001/0", req_ready, wren); end
      @(negedge clk);
      req_valid = 4'h0;
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) mem[a] = init_val(a);
      test_reset();
      test_round_robin();
      test_rw_same_addr();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_writes_only();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
